// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lockout controller.
package lock_pkg;

    localparam int unsigned KEY_WIDTH = 4;

    typedef enum logic [1:0] {
        PASS    = 2'd0,
        LOCKOUT = 2'd1,
        RELEASE = 2'd2
    } ctrl_state_e;

    localparam logic [KEY_WIDTH-1:0] KEY_ZERO     = '0;
    localparam int unsigned          ATTEMPT_ZERO = 0;
    localparam int unsigned          TIMER_ZERO   = 0;

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter; expire_o is high exactly while the count equals 1.
module lockout_timer #(
    parameter int unsigned TIMER_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic [TIMER_WIDTH-1:0] load_value_i,
    output logic [TIMER_WIDTH-1:0] value_o,
    output logic                   expire_o
);

    logic [TIMER_WIDTH-1:0] count_q, count_d;
    logic                   expire_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (count_q != TIMER_WIDTH'(0)) begin
            count_d = count_q - TIMER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= '0;
            expire_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            expire_q <= (count_d == TIMER_WIDTH'(1));
        end
    end

    assign value_o  = count_q;
    assign expire_o = expire_q;

endmodule

// File: rtl/lock_attempt_controller.sv
// Keypad gate in front of the lock: counts failed entries and masks keys for a lockout period.
// Build option LOCKOUT_ESCALATE_EN doubles the lockout per escalation level; otherwise level stays 0.
module lock_attempt_controller
    import lock_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ    = 50000000,
    parameter int unsigned MAX_ATTEMPTS  = 3,
    parameter int unsigned BASE_LOCKOUT  = 5 * CLOCK_FREQ,
    parameter int unsigned MAX_LEVEL     = 3,
    parameter int unsigned ATTEMPT_WIDTH = $clog2(MAX_ATTEMPTS + 1),
    parameter int unsigned LEVEL_WIDTH   = $clog2(MAX_LEVEL + 1),
`ifdef LOCKOUT_ESCALATE_EN
    parameter int unsigned TIMER_WIDTH   = $clog2((BASE_LOCKOUT << MAX_LEVEL) + 1)
`else
    parameter int unsigned TIMER_WIDTH   = $clog2(BASE_LOCKOUT + 1)
`endif
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [KEY_WIDTH-1:0]     key_in,
    input  logic                     lock_error,
    input  logic                     lock_locked,
    output logic [KEY_WIDTH-1:0]     key_out,
    output logic                     lockout,
    output logic [ATTEMPT_WIDTH-1:0] attempts,
    output logic [LEVEL_WIDTH-1:0]   level,
    output logic [1:0]               ctrl_state
);

    ctrl_state_e              state_q, state_d;
    logic [KEY_WIDTH-1:0]     key_q, key_d;
    logic [ATTEMPT_WIDTH-1:0] attempts_q, attempts_d;
    logic [LEVEL_WIDTH-1:0]   level_q, level_d;
    logic                     error_q, locked_q;
    logic                     fail_c, success_c;
    logic                     timer_load;
    logic [TIMER_WIDTH-1:0]   timer_load_value;
    logic [TIMER_WIDTH-1:0]   timer_value;
    logic                     timer_expire;

    assign fail_c    = lock_error & ~error_q;
    assign success_c = lock_locked ^ locked_q;

`ifdef LOCKOUT_ESCALATE_EN
    assign timer_load_value = TIMER_WIDTH'(BASE_LOCKOUT) << level_q;
`else
    assign timer_load_value = TIMER_WIDTH'(BASE_LOCKOUT);
`endif

    lockout_timer #(
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_timer (
        .clk_i        (clock),
        .rst_i        (reset),
        .load_i       (timer_load),
        .load_value_i (timer_load_value),
        .value_o      (timer_value),
        .expire_o     (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        attempts_d = attempts_q;
        level_d    = level_q;
        timer_load = 1'b0;
        case (state_q)
            PASS: begin
                key_d = key_in;
                if (success_c) begin
                    attempts_d = ATTEMPT_WIDTH'(ATTEMPT_ZERO);
                    level_d    = '0;
                end else if (fail_c) begin
                    if (attempts_q >= ATTEMPT_WIDTH'(MAX_ATTEMPTS - 1)) begin
                        attempts_d = ATTEMPT_WIDTH'(ATTEMPT_ZERO);
                        timer_load = 1'b1;
                        key_d      = KEY_ZERO;
                        state_d    = LOCKOUT;
                    end else begin
                        attempts_d = attempts_q + ATTEMPT_WIDTH'(1);
                    end
                end
            end
            LOCKOUT: begin
                key_d = KEY_ZERO;
                // A drained timer also ends the lockout so the FSM cannot stall here.
                if (timer_expire || timer_value == TIMER_WIDTH'(TIMER_ZERO)) begin
                    state_d = RELEASE;
`ifdef LOCKOUT_ESCALATE_EN
                    if (level_q < LEVEL_WIDTH'(MAX_LEVEL)) begin
                        level_d = level_q + LEVEL_WIDTH'(1);
                    end
`endif
                end
                if (success_c) begin
                    attempts_d = ATTEMPT_WIDTH'(ATTEMPT_ZERO);
                    level_d    = '0;
                end
            end
            RELEASE: begin
                key_d = KEY_ZERO;
                if (key_in == KEY_ZERO) begin
                    state_d = PASS;
                end
            end
            default: begin
                key_d   = KEY_ZERO;
                state_d = PASS;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= PASS;
            key_q      <= KEY_ZERO;
            attempts_q <= '0;
            level_q    <= '0;
            error_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            attempts_q <= attempts_d;
            level_q    <= level_d;
            error_q    <= lock_error;
            locked_q   <= lock_locked;
        end
    end

    assign key_out    = key_q;
    assign lockout    = (state_q != PASS);
    assign attempts   = attempts_q;
    assign level      = level_q;
    assign ctrl_state = state_q;

endmodule

// File: tb/tb_lock_attempt_controller.sv
// Self-checking bench for lock_attempt_controller against a cycle-level behavioural model.
module tb_lock_attempt_controller;

    localparam int T_BASE    = 20;
    localparam int T_MAX_ATT = 3;
    localparam int T_MAX_LVL = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] key_in;
    logic       lock_error;
    logic       lock_locked;
    logic [3:0] key_out;
    logic       lockout;
    logic [1:0] attempts;
    logic [1:0] level;
    logic [1:0] ctrl_state;

    always #5 clock = ~clock;

    lock_attempt_controller #(
        .CLOCK_FREQ   (10),
        .MAX_ATTEMPTS (T_MAX_ATT),
        .BASE_LOCKOUT (T_BASE),
        .MAX_LEVEL    (T_MAX_LVL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_in      (key_in),
        .lock_error  (lock_error),
        .lock_locked (lock_locked),
        .key_out     (key_out),
        .lockout     (lockout),
        .attempts    (attempts),
        .level       (level),
        .ctrl_state  (ctrl_state)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: mode 0 = accepting keys, 1 = keys masked, 2 = waiting for release
    int         m_mode, m_att, m_lvl, m_rem;
    logic [3:0] m_key;
    logic       m_err_prev, m_lck_prev;
    logic       cur_l;

    task automatic model_reset();
        m_mode = 0; m_att = 0; m_lvl = 0; m_rem = 0;
        m_key = 4'h0; m_err_prev = 1'b0; m_lck_prev = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] k, input logic e, input logic l);
        bit fail, succ;
        fail = e && !m_err_prev;
        succ = (l != m_lck_prev);
        case (m_mode)
            0: begin
                m_key = k;
                if (succ) begin
                    m_att = 0; m_lvl = 0;
                end else if (fail) begin
                    if (m_att + 1 >= T_MAX_ATT) begin
                        m_att = 0; m_key = 4'h0; m_mode = 1;
`ifdef LOCKOUT_ESCALATE_EN
                        m_rem = T_BASE * (2 ** m_lvl);
`else
                        m_rem = T_BASE;
`endif
                    end else begin
                        m_att++;
                    end
                end
            end
            1: begin
                m_key = 4'h0;
                m_rem--;
                if (m_rem == 0) begin
                    m_mode = 2;
`ifdef LOCKOUT_ESCALATE_EN
                    if (m_lvl < T_MAX_LVL) m_lvl++;
`endif
                end
                if (succ) begin
                    m_att = 0; m_lvl = 0;
                end
            end
            default: begin
                m_key = 4'h0;
                if (k == 4'h0) m_mode = 0;
            end
        endcase
        m_err_prev = e;
        m_lck_prev = l;
    endtask

    task automatic drive(input logic [3:0] k, input logic e, input logic l);
        @(negedge clock);
        key_in = k; lock_error = e; lock_locked = l; cur_l = l;
        model_step(k, e, l);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (key_out !== 4'h0) begin failures++; $display("FAIL reset_key_out got=%0h exp=0", key_out); end
        checks++; if (lockout !== 1'b0) begin failures++; $display("FAIL reset_lockout got=%0b exp=0", lockout); end
        checks++; if (attempts !== 2'd0) begin failures++; $display("FAIL reset_attempts got=%0d exp=0", attempts); end
        checks++; if (level !== 2'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (ctrl_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", ctrl_state); end
    endtask

    task automatic test_pass_through();
        drive(4'h8, 1'b0, cur_l);
        checks++; if (key_out !== 4'h8) begin failures++; $display("FAIL pass_key8 got=%0h exp=8", key_out); end
        checks++; if (lockout !== 1'b0) begin failures++; $display("FAIL pass_lockout got=%0b exp=0", lockout); end
        drive(4'h3, 1'b0, cur_l);
        checks++; if (key_out !== 4'h3) begin failures++; $display("FAIL pass_key3 got=%0h exp=3", key_out); end
        drive(4'h0, 1'b0, cur_l);
        checks++; if (key_out !== 4'h0) begin failures++; $display("FAIL pass_key0 got=%0h exp=0", key_out); end
    endtask

    task automatic test_success_clears();
        drive(4'h0, 1'b1, cur_l);
        checks++; if (attempts !== 2'd1) begin failures++; $display("FAIL succ_att1 got=%0d exp=1", attempts); end
        drive(4'h0, 1'b1, cur_l);
        checks++; if (attempts !== 2'd1) begin failures++; $display("FAIL succ_level_err got=%0d exp=1", attempts); end
        drive(4'h0, 1'b0, cur_l);
        drive(4'h0, 1'b1, cur_l);
        checks++; if (attempts !== 2'd2) begin failures++; $display("FAIL succ_att2 got=%0d exp=2", attempts); end
        drive(4'h0, 1'b0, cur_l);
        drive(4'h0, 1'b0, ~cur_l);
        checks++; if (attempts !== 2'd0) begin failures++; $display("FAIL succ_att0 got=%0d exp=0", attempts); end
        checks++; if (level !== 2'd0) begin failures++; $display("FAIL succ_level got=%0d exp=0", level); end
        checks++; if (lockout !== 1'b0) begin failures++; $display("FAIL succ_lockout got=%0b exp=0", lockout); end
    endtask

    task automatic test_lockout_series(input int exp_len, input int exp_lvl);
        int n;
        bit timed_out;
        drive(4'h1, 1'b1, cur_l);
        drive(4'h1, 1'b0, cur_l);
        drive(4'h1, 1'b1, cur_l);
        drive(4'h1, 1'b0, cur_l);
        drive(4'h1, 1'b1, cur_l);
        checks++; if (lockout !== 1'b1) begin failures++; $display("FAIL series_enter_lockout got=%0b exp=1", lockout); end
        checks++; if (key_out !== 4'h0) begin failures++; $display("FAIL series_enter_key got=%0h exp=0", key_out); end
        n = 1;
        timed_out = 1'b0;
        while (1) begin
            drive(4'h1, 1'b0, cur_l);
            checks++; if (key_out !== 4'h0) begin failures++; $display("FAIL series_masked_key got=%0h exp=0", key_out); end
            if (ctrl_state != 2'd1) break;
            n++;
            if (n > 300) begin timed_out = 1'b1; break; end
        end
        checks++; if (timed_out) begin failures++; $display("FAIL series_timeout got=%0d exp=%0d", n, exp_len); end
        checks++; if (n !== exp_len) begin failures++; $display("FAIL series_len got=%0d exp=%0d", n, exp_len); end
        for (int i = 0; i < 3; i++) begin
            drive(4'h1, 1'b0, cur_l);
            checks++; if (ctrl_state !== 2'd2) begin failures++; $display("FAIL series_release_hold got=%0d exp=2", ctrl_state); end
            checks++; if (lockout !== 1'b1) begin failures++; $display("FAIL series_release_lockout got=%0b exp=1", lockout); end
        end
        drive(4'h0, 1'b0, cur_l);
        checks++; if (ctrl_state !== 2'd0) begin failures++; $display("FAIL series_back_pass got=%0d exp=0", ctrl_state); end
        checks++; if (level !== 2'(exp_lvl)) begin failures++; $display("FAIL series_level got=%0d exp=%0d", level, exp_lvl); end
        checks++; if (attempts !== 2'd0) begin failures++; $display("FAIL series_attempts got=%0d exp=0", attempts); end
        drive(4'h5, 1'b0, cur_l);
        checks++; if (key_out !== 4'h5) begin failures++; $display("FAIL series_resume_key got=%0h exp=5", key_out); end
        drive(4'h0, 1'b0, cur_l);
    endtask

    task automatic test_simultaneous();
        drive(4'h0, 1'b1, cur_l);
        drive(4'h0, 1'b0, cur_l);
        drive(4'h0, 1'b1, cur_l);
        drive(4'h0, 1'b0, cur_l);
        checks++; if (attempts !== 2'd2) begin failures++; $display("FAIL simul_pre_att got=%0d exp=2", attempts); end
        drive(4'h0, 1'b1, ~cur_l);
        checks++; if (attempts !== 2'd0) begin failures++; $display("FAIL simul_att got=%0d exp=0", attempts); end
        checks++; if (lockout !== 1'b0) begin failures++; $display("FAIL simul_lockout got=%0b exp=0", lockout); end
        checks++; if (level !== 2'd0) begin failures++; $display("FAIL simul_level got=%0d exp=0", level); end
        drive(4'h0, 1'b0, cur_l);
    endtask

    task automatic test_reset_mid();
        int guard;
`ifdef LOCKOUT_ESCALATE_EN
        test_lockout_series(20, 1);
`else
        test_lockout_series(20, 0);
`endif
        drive(4'h2, 1'b1, cur_l);
        drive(4'h2, 1'b0, cur_l);
        drive(4'h2, 1'b1, cur_l);
        drive(4'h2, 1'b0, cur_l);
        drive(4'h2, 1'b1, cur_l);
        guard = 0;
        while (m_rem > 10 && guard < 200) begin
            drive(4'h2, 1'b0, cur_l);
            guard++;
        end
        checks++; if (ctrl_state !== 2'd1) begin failures++; $display("FAIL rstmid_pre_state got=%0d exp=1", ctrl_state); end
        #2 reset = 1'b1;
        #1;
        checks++; if (lockout !== 1'b0) begin failures++; $display("FAIL rstmid_lockout got=%0b exp=0", lockout); end
        checks++; if (ctrl_state !== 2'd0) begin failures++; $display("FAIL rstmid_state got=%0d exp=0", ctrl_state); end
        checks++; if (attempts !== 2'd0) begin failures++; $display("FAIL rstmid_attempts got=%0d exp=0", attempts); end
        checks++; if (level !== 2'd0) begin failures++; $display("FAIL rstmid_level got=%0d exp=0", level); end
        checks++; if (key_out !== 4'h0) begin failures++; $display("FAIL rstmid_key got=%0h exp=0", key_out); end
        model_reset();
        @(negedge clock);
        lock_error = 1'b0;
        key_in = 4'h0;
        @(negedge clock);
        reset = 1'b0;
        drive(4'h0, 1'b0, cur_l);
        checks++; if (ctrl_state !== 2'd0) begin failures++; $display("FAIL rstmid_after_state got=%0d exp=0", ctrl_state); end
        checks++; if (level !== 2'd0) begin failures++; $display("FAIL rstmid_after_level got=%0d exp=0", level); end
    endtask

    task automatic test_random();
        logic [3:0] k;
        logic       e, l;
        k = 4'h0;
        l = cur_l;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) k = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            e = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) l = ~l;
            drive(k, e, l);
            checks++; if (key_out !== m_key) begin failures++; $display("FAIL rand_key cyc=%0d got=%0h exp=%0h", i, key_out, m_key); end
            checks++; if (lockout !== (m_mode != 0)) begin failures++; $display("FAIL rand_lockout cyc=%0d got=%0b exp=%0b", i, lockout, m_mode != 0); end
            checks++; if (attempts !== 2'(m_att)) begin failures++; $display("FAIL rand_attempts cyc=%0d got=%0d exp=%0d", i, attempts, m_att); end
            checks++; if (level !== 2'(m_lvl)) begin failures++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", i, level, m_lvl); end
            checks++; if (ctrl_state !== 2'(m_mode)) begin failures++; $display("FAIL rand_state cyc=%0d got=%0d exp=%0d", i, ctrl_state, m_mode); end
        end
    endtask

    initial begin
        reset = 1'b1;
        key_in = 4'h0;
        lock_error = 1'b0;
        lock_locked = 1'b0;
        cur_l = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        @(negedge clock);
        reset = 1'b0;
        test_pass_through();
        test_success_clears();
`ifdef LOCKOUT_ESCALATE_EN
        test_lockout_series(20, 1);
        test_lockout_series(40, 2);
        test_lockout_series(80, 2);
        test_lockout_series(80, 2);
`else
        test_lockout_series(20, 0);
        test_lockout_series(20, 0);
        test_lockout_series(20, 0);
`endif
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lock_attempt_controller.md
Name: lock_attempt_controller

Overview:
- Sits between the debounced keypad and digitalLock; forwards keys to the lock and watches its locked/error outputs.
- Counts consecutive failed code entries. After MAX_ATTEMPTS failures it masks all keys for a lockout period, then waits for all keys to be released before accepting input again.
- A successful lock or unlock clears the failure history.

Parameters:
- CLOCK_FREQ, 50000000, system clock frequency in Hz.
- MAX_ATTEMPTS, 3, consecutive failures that trigger a lockout (must be >= 1).
- BASE_LOCKOUT, 5*CLOCK_FREQ, lockout duration in clock cycles at level 0 (must be >= 1).
- MAX_LEVEL, 3, maximum escalation level.
- ATTEMPT_WIDTH, $clog2(MAX_ATTEMPTS+1), width of the attempt counter.
- LEVEL_WIDTH, $clog2(MAX_LEVEL+1), width of the level counter.
- TIMER_WIDTH, $clog2((BASE_LOCKOUT<<MAX_LEVEL)+1), width of the lockout timer.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- key_in  in  4  debounced keypad code; 0 means no key pressed.
- lock_error  in  1  error output of the lock.
- lock_locked  in  1  locked output of the lock.
- key_out  out  4  registered key code to the lock.
- lockout  out  1  high while keys are masked (LOCKOUT or RELEASE state).
- attempts  out  ATTEMPT_WIDTH  consecutive failure count.
- level  out  LEVEL_WIDTH  current escalation level.
- ctrl_state  out  2  state encoding, for testing.

Behaviour:
- Reset (asynchronous): state=PASS, key_out=0, lockout=0, attempts=0, level=0, timer=0, error_q=0, locked_q=0.
- Registers error_q and locked_q hold the previous-cycle values of lock_error and lock_locked.
- fail = lock_error & ~error_q (rising edge). A lock timeout also raises error and therefore also counts as a failure.
- success = lock_locked ^ locked_q (any toggle of locked).
- PASS (2'd0):
  - key_out <= key_in (one cycle of latency).
  - If success: attempts <= 0, level <= 0. Success wins over fail in the same cycle.
  - Else if fail and attempts == MAX_ATTEMPTS-1: attempts <= 0; timer <= BASE_LOCKOUT << level; key_out <= 0; state <= LOCKOUT.
  - Else if fail: attempts <= attempts + 1.
- LOCKOUT (2'd1):
  - key_out = 0; the timer decrements by 1 each cycle.
  - When timer == 1: state <= RELEASE, and level <= level+1 saturating at MAX_LEVEL.
  - A fail edge in this state is ignored. A success edge sets level <= 0 and attempts <= 0 but does not end the lockout.
- RELEASE (2'd2):
  - key_out = 0.
  - When key_in == 0: state <= PASS. Forwarding resumes in the next cycle, so a key held through the lockout is never delivered mid-press.
- 2'd3 is illegal and recovers to PASS with key_out=0.
- lockout = (state != PASS); it is combinational from state.
- Lockout length, measured from the cycle after the fail edge until the state reaches RELEASE, is exactly BASE_LOCKOUT << level_at_entry cycles.
- Asserting reset mid-lockout aborts it immediately; all registers return to their reset values.
- All counters saturate; none wrap.

Optional Feature:
- Macro: LOCKOUT_ESCALATE_EN.
- Defined: level increments per lockout as described above, and the duration doubles per level.
- Undefined: level is held at 0, the duration is always BASE_LOCKOUT, and TIMER_WIDTH may be computed without the MAX_LEVEL shift.

Decomposition:
- Package lock_pkg:
  - Controller state typedef/localparams: PASS, LOCKOUT, RELEASE.
  - Zero constants for the key, attempt and timer widths.
  - KEY_WIDTH=4.
- Sub-module lockout_timer:
  - Loadable down-counter with load, value and expire (value==1 while running) outputs; parameter TIMER_WIDTH.
  - Instantiated once.

Test Plan (CLOCK_FREQ=10, BASE_LOCKOUT=20, MAX_ATTEMPTS=3, MAX_LEVEL=2, escalation on):
- Pass-through: key_in=4'h8 at cycle N -> key_out=4'h8 at N+1; lockout=0.
- Two error pulses followed by a locked toggle -> attempts 1, 2, then 0; level=0; no lockout.
- Three error rising edges -> lockout=1 and key_out=0 in the cycle after the third edge. Hold key_in=4'h1 throughout: state reaches RELEASE after 20 cycles, stays there until key_in=0, then PASS; level=1.
- Second lockout series -> lasts 40 cycles; third series -> 80 cycles, level saturates at 2; a fourth series stays at 80.
- Error edge and locked toggle in the same cycle while attempts=2 -> no lockout, attempts=0.
- Assert reset with 10 cycles of lockout remaining -> lockout=0, state=PASS, attempts=0, level=0 immediately (asynchronous).
